// File: rtl/fec_msg_fifo.sv
// fec_msg_fifo: synchronous single-clock message FIFO with registered read data.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   flush           synchronous clear of pointers/occupancy (memory, data_out, error flags kept)
//   wr_en, data_in  write request and data
//   rd_en           read request; data_out/rd_valid follow one cycle later
//   clr_err         clears sticky overflow/underflow
//   data_out        last read word (held between reads)
//   rd_valid        data_out was loaded by a read accepted in the previous cycle
//   empty, full, almost_empty, almost_full, count   occupancy status
//   overflow, underflow   sticky error flags
module fec_msg_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 1024,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         data_out,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;
  logic             ovf_evt;
  logic             unf_evt;

  // Full/empty gate the requests, so a simultaneous request at full only
  // reads and at empty only writes (no bypass of the written word).
  assign wr_ok   = wr_en & ~flush & ~full;
  assign rd_ok   = rd_en & ~flush & ~empty;
  assign ovf_evt = wr_en & ~flush & full;
  assign unf_evt = rd_en & ~flush & empty;

  assign empty        = (count == '0);
  assign full         = (count == CNT_FULL);
  assign almost_empty = (count <= CNT_AE);
  assign almost_full  = (count >= CNT_AF);

  // No reset on the storage so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) data_out <= mem[rd_ptr];

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
        if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
        case ({wr_ok, rd_ok})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end

      // A new error event outranks a clear in the same cycle.
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_evt)       underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fec_msg_fifo.sv
module tb_fec_msg_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  int checks;
  int failures;

  fec_msg_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .clr_err(clr_err), .data_out(data_out), .rd_valid(rd_valid),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_count"},    32'(count), 0);
    check_eq({tag, "_empty"},    32'(empty), 1);
    check_eq({tag, "_aempty"},   32'(almost_empty), 1);
    check_eq({tag, "_full"},     32'(full), 0);
    check_eq({tag, "_afull"},    32'(almost_full), 0);
    check_eq({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check_eq({tag, "_data_out"}, data_out, 0);
    check_eq({tag, "_ovf"},      32'(overflow), 0);
    check_eq({tag, "_unf"},      32'(underflow), 0);
  endtask

  initial begin
    logic [31:0] q[$];
    int mc, sent, rcvd, cyc;
    logic do_wr, do_rd;

    checks = 0; failures = 0;
    rst_n = 1'b0; data_in = '0;
    idle();
    #3;
    check_reset_values("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Fill 1..8
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; data_in = 32'(i);
      tick();
      check_eq($sformatf("fill_count%0d", i), 32'(count), 32'(i));
      check_eq($sformatf("fill_afull%0d", i), 32'(almost_full), 32'(i >= 6));
      check_eq($sformatf("fill_full%0d", i),  32'(full), 32'(i == 8));
      check_eq($sformatf("fill_aempty%0d", i), 32'(almost_empty), 32'(i <= 2));
    end

    // Overflow while full
    wr_en = 1'b1; data_in = 32'hDEAD;
    tick();
    check_eq("ovf_set", 32'(overflow), 1);
    check_eq("ovf_count", 32'(count), 8);
    idle(); clr_err = 1'b1;
    tick();
    check_eq("ovf_clr", 32'(overflow), 0);
    idle();

    // Drain 1..8
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      check_eq($sformatf("drain_valid%0d", i), 32'(rd_valid), 1);
      check_eq($sformatf("drain_data%0d", i), data_out, 32'(i));
      check_eq($sformatf("drain_count%0d", i), 32'(count), 32'(8 - i));
    end
    idle();
    tick();
    check_eq("drain_valid_off", 32'(rd_valid), 0);
    check_eq("drain_empty", 32'(empty), 1);
    check_eq("drain_hold", data_out, 8);

    // Simultaneous at count=3
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; data_in = 32'(100 + i);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_in = 32'(103 + k);
      tick();
      check_eq($sformatf("sim_count%0d", k), 32'(count), 3);
      check_eq($sformatf("sim_data%0d", k), data_out, 32'(100 + k));
      check_eq($sformatf("sim_valid%0d", k), 32'(rd_valid), 1);
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      rd_en = 1'b1;
      tick();
      check_eq($sformatf("sim_tail%0d", k), data_out, 32'(110 + k));
    end
    idle();

    // Simultaneous at empty: write only, underflow, no bypass
    wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h55;
    tick();
    check_eq("empty_both_count", 32'(count), 1);
    check_eq("empty_both_unf", 32'(underflow), 1);
    check_eq("empty_both_valid", 32'(rd_valid), 0);
    check_eq("empty_both_nobypass", data_out, 112);
    idle(); rd_en = 1'b1;
    tick();
    check_eq("empty_both_read", data_out, 32'h55);
    // error event beats clear in the same cycle
    rd_en = 1'b1; clr_err = 1'b1;
    tick();
    check_eq("unf_priority", 32'(underflow), 1);
    idle(); clr_err = 1'b1;
    tick();
    check_eq("unf_clr", 32'(underflow), 0);
    idle();

    // Wrap: 20 words streamed with occupancy held in 2..5 once primed
    mc = 0; sent = 0; rcvd = 0; cyc = 0;
    while ((rcvd < 20) && (cyc < 200)) begin
      do_wr = (sent < 20) && (mc < 5) && ((cyc % 3) != 2);
      do_rd = (mc > 2) || ((sent == 20) && (mc > 0));
      wr_en = do_wr; rd_en = do_rd; data_in = 32'h1000 + 32'(sent);
      tick();
      if (do_wr) begin q.push_back(32'h1000 + 32'(sent)); sent++; end
      if (do_rd) begin
        check_eq($sformatf("wrap_valid%0d", rcvd), 32'(rd_valid), 1);
        check_eq($sformatf("wrap_data%0d", rcvd), data_out, q.pop_front());
        rcvd++;
      end
      mc = mc + int'(do_wr) - int'(do_rd);
      check_eq($sformatf("wrap_count%0d", cyc), 32'(count), 32'(mc));
      cyc++;
    end
    check_eq("wrap_done", 32'(rcvd), 20);
    idle();

    // Flush with write at count=5
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = 32'(32'h200 + i);
      tick();
    end
    check_eq("pre_flush_count", 32'(count), 5);
    wr_en = 1'b1; flush = 1'b1; data_in = 32'hBEEF;
    tick();
    check_eq("flush_count", 32'(count), 0);
    check_eq("flush_empty", 32'(empty), 1);
    check_eq("flush_valid", 32'(rd_valid), 0);
    check_eq("flush_hold", data_out, 32'h1013);
    idle(); wr_en = 1'b1; data_in = 32'h300;
    tick();
    idle(); rd_en = 1'b1;
    tick();
    check_eq("post_flush_read", data_out, 32'h300);
    idle();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; data_in = 32'(32'h400 + i);
      tick();
    end
    idle(); rd_en = 1'b1; wr_en = 1'b1; data_in = 32'h403;
    tick();
    check_eq("pre_rst_data", data_out, 32'h400);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    idle();
    tick();
    rst_n = 1'b1;
    wr_en = 1'b1; data_in = 32'h500;
    tick();
    idle(); rd_en = 1'b1;
    tick();
    check_eq("post_rst_read", data_out, 32'h500);
    check_eq("post_rst_valid", 32'(rd_valid), 1);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fec_msg_fifo.md
FEC_MSG_FIFO -- requirements
Module: fec_msg_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 1024, which sets the number of entries; legal values are powers of 2 and at least 4.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-4, the almost_full threshold; legal range is 1..DEPTH-1.
REQ-004 The block SHALL have parameter AE_LEVEL, default 4, the almost_empty threshold; legal range is 1..DEPTH-1.
REQ-005 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 flush  input  1  synchronous clear of FIFO contents.
REQ-008 wr_en  input  1  write request.
REQ-009 data_in  input  WIDTH  write data (message_data_t when WIDTH=32).
REQ-010 rd_en  input  1  read request.
REQ-011 clr_err  input  1  clears the sticky error flags.
REQ-012 data_out  output  WIDTH  registered read data.
REQ-013 rd_valid  output  1  data_out holds a newly read word this cycle.
REQ-014 empty, full  output  1 each  occupancy is 0 / occupancy is DEPTH.
REQ-015 almost_empty, almost_full  output  1 each  occupancy <= AE_LEVEL / occupancy >= AF_LEVEL.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 A write SHALL be accepted when wr_en=1, flush=0 and full=0; data_in is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-019 A read SHALL be accepted when rd_en=1, flush=0 and empty=0; mem[rd_ptr] is registered into data_out and rd_ptr increments modulo DEPTH.
REQ-020 Read latency SHALL be 1 cycle: rd_valid=1 in the cycle after an accepted read and 0 otherwise.
REQ-021 data_out SHALL hold its last value when no read is accepted; it is never forced to 0 outside reset.
REQ-022 count SHALL update each cycle by +1 on a write only, -1 on a read only, and 0 when both are accepted or neither is.
REQ-023 empty, full, almost_empty and almost_full SHALL be pure decodes of the registered count, so they change in the same cycle as count.
REQ-024 When the FIFO is full and wr_en=rd_en=1, the read SHALL be accepted, the write rejected, and overflow set.
REQ-025 When the FIFO is empty and wr_en=rd_en=1, the write SHALL be accepted, the read rejected, underflow set, and rd_valid=0 on the next cycle; the written word is not bypassed to the output.
REQ-026 When 0 < count < DEPTH and wr_en=rd_en=1, both operations SHALL be accepted and count is unchanged.
REQ-027 overflow SHALL be set on the cycle after wr_en=1 with full=1 (flush=0); underflow SHALL be set on the cycle after rd_en=1 with empty=1 (flush=0).
REQ-028 clr_err=1 SHALL clear both error flags on the next cycle; a new error event in the same cycle takes priority and leaves the flag set.
REQ-029 flush=1 SHALL take priority over wr_en and rd_en: the next cycle has wr_ptr=rd_ptr=0, count=0 and rd_valid=0; data_out, the memory contents and the error flags are unchanged.
REQ-030 Pointer wrap SHALL be seamless: a write at index DEPTH-1 is followed by a write at index 0, and data order is preserved across the wrap.
REQ-031 Memory SHALL not be reset, so it can be inferred as RAM; no read may return an entry that was never written.

Reset
REQ-032 While rst_n=0: wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, data_out=0, overflow=0, underflow=0.
REQ-033 Reset asserted mid-operation SHALL discard all contents immediately; after deassertion the first accepted read returns the first word written after reset.

Verification
REQ-034 Fill/drain (DEPTH=8, AF=6, AE=2): write 1..8 -> full=1 and count=8 after the 8th write, with almost_full from count=6; read 8 -> data 1..8 in order, each with rd_valid one cycle after rd_en; empty=1 at the end.
REQ-035 Overflow: with the FIFO full, pulse wr_en with data_in=0xDEAD -> overflow=1, count stays 8, 0xDEAD is never read; clr_err -> overflow=0.
REQ-036 Simultaneous operations: at count=3, wr_en=rd_en=1 for 10 cycles -> count stays 3 and data order is preserved; at count=0 both set -> count=1, underflow=1, rd_valid=0.
REQ-037 Wrap: with DEPTH=8, run 20 words through while keeping count between 2 and 5 -> the output sequence equals the input sequence.
REQ-038 Flush and reset: at count=5, assert flush together with wr_en -> count=0, empty=1, data_out unchanged; separately, assert rst_n low mid-stream -> all outputs take the REQ-032 values asynchronously.
